instr_sequencer: RTL and testbench

// Upstream feeder for the multi-cycle processor: holds a loadable program store and issues one
// 16-bit instruction at a time on DIN/Run, holds it until the processor pulses Done, then

---
 rtl/seq_pkg.sv | 33 +++
 rtl/program_rom.sv | 24 ++
 rtl/instr_sequencer.sv | 172 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, the HALT word
// and the opcode numbering used by the downstream multi-cycle processor.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_RETIRE,
        S_HALT,
        S_FAULT
    } seq_state_t;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_MVNZ = 4'd8;
    localparam logic [3:0] OP_LD   = 4'd9;
    localparam logic [3:0] OP_SD   = 4'd10;

    function automatic logic is_busy(input seq_state_t s);
        return (s == S_FETCH) || (s == S_ISSUE) || (s == S_WAIT) || (s == S_RETIRE);
    endfunction

endpackage

// File: rtl/program_rom.sv
// Program store: 2**AW words of 16 bits, one synchronous write port and one
// synchronous read port (read data valid the cycle after re).
module program_rom #(
    parameter int AW = 4
) (
    input  logic          Clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [2**AW];

    always_ff @(posedge Clock) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_sequencer.sv
// Feeds the multi-cycle processor one instruction at a time from a loadable
// program store, with start/stop control, HALT detection, watchdog and retire count.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int AW      = 4,
    parameter bit WRAP    = 1'b1,
    parameter int TIMEOUT = 64
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stop,
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [15:0]   LoadData,
    input  logic          Done,
    output logic [15:0]   DIN,
    output logic          Run,
    output logic [AW-1:0] Pc,
    output logic          Busy,
    output logic          Halted,
    output logic          Timeout,
    output logic [15:0]   InstrCount
);

    localparam int              WDW     = $clog2(TIMEOUT);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [AW-1:0]   PC_LAST = '1;

    seq_state_t     state_q, state_n;
    logic [AW-1:0]  pc_q, pc_n;
    logic [15:0]    din_q, din_n;
    logic           run_q, run_n;
    logic           busy_q, busy_n;
    logic           halted_q, halted_n;
    logic           timeout_q, timeout_n;
    logic [15:0]    count_q, count_n;
    logic [WDW-1:0] wd_q, wd_n;
    logic           stop_q, stop_n;

    logic           idle_like;
    logic           rom_we;
    logic           rom_re;
    logic [15:0]    rom_word;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_FAULT);
    assign rom_we    = LoadEn && idle_like;
    assign rom_re    = (state_q == S_FETCH);

    program_rom #(.AW(AW)) u_rom (
        .Clock (Clock),
        .we    (rom_we),
        .waddr (LoadAddr),
        .wdata (LoadData),
        .re    (rom_re),
        .raddr (pc_q),
        .rdata (rom_word)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            din_q     <= '0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
            wd_q      <= '0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            din_q     <= din_n;
            run_q     <= run_n;
            busy_q    <= busy_n;
            halted_q  <= halted_n;
            timeout_q <= timeout_n;
            count_q   <= count_n;
            wd_q      <= wd_n;
            stop_q    <= stop_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        din_n     = din_q;
        run_n     = run_q;
        timeout_n = timeout_q;
        count_n   = count_q;
        wd_n      = wd_q;
        stop_n    = stop_q;

        case (state_q)
            S_IDLE, S_HALT, S_FAULT: begin
                if (Start && !Stop) begin
                    state_n   = S_FETCH;
                    pc_n      = '0;
                    count_n   = '0;
                    timeout_n = 1'b0;
                    stop_n    = 1'b0;
                end
            end
            S_FETCH: begin
                if (Stop)
                    stop_n = 1'b1;
                state_n = S_ISSUE;
            end
            S_ISSUE: begin
                if (Stop)
                    stop_n = 1'b1;
                din_n = rom_word;
                if (rom_word == HALT_WORD) begin
                    state_n = S_HALT;
                end else begin
                    run_n   = 1'b1;
                    wd_n    = '0;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Stop)
                    stop_n = 1'b1;
                // Done on the expiry cycle still retires the instruction
                if (Done) begin
                    run_n   = 1'b0;
                    state_n = S_RETIRE;
                end else if (wd_q == WD_LAST) begin
                    run_n     = 1'b0;
                    timeout_n = 1'b1;
                    state_n   = S_FAULT;
                end else begin
                    wd_n = wd_q + 1'b1;
                end
            end
            S_RETIRE: begin
                if (count_q != '1)
                    count_n = count_q + 16'd1;
                if (Stop || stop_q) begin
                    stop_n  = 1'b0;
                    state_n = S_IDLE;
                end else if (pc_q == PC_LAST) begin
                    if (WRAP) begin
                        pc_n    = '0;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_HALT;
                    end
                end else begin
                    pc_n    = pc_q + 1'b1;
                    state_n = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n   = is_busy(state_n);
        halted_n = (state_n == S_HALT);
    end

    assign DIN        = din_q;
    assign Run        = run_q;
    assign Pc         = pc_q;
    assign Busy       = busy_q;
    assign Halted     = halted_q;
    assign Timeout    = timeout_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (AW=2, WRAP=1, TIMEOUT=64): HALT program,
// wrap-around, watchdog fault, stop, load gating and reset mid-instruction.
module tb_instr_sequencer;

    localparam int AW = 2;

    logic          Clock;
    logic          Reset;
    logic          Start;
    logic          Stop;
    logic          LoadEn;
    logic [AW-1:0] LoadAddr;
    logic [15:0]   LoadData;
    logic          Done;
    logic [15:0]   DIN;
    logic          Run;
    logic [AW-1:0] Pc;
    logic          Busy;
    logic          Halted;
    logic          Timeout;
    logic [15:0]   InstrCount;

    int total = 0;
    int bad   = 0;

    logic [15:0] prog1 [4] = '{16'h0280, 16'h1405, 16'h24C0, 16'hFFFF};
    logic [15:0] prog2 [4] = '{16'h0280, 16'h1405, 16'h24C0, 16'h3001};

    instr_sequencer #(.AW(AW), .WRAP(1'b1), .TIMEOUT(64)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Stop       (Stop),
        .LoadEn     (LoadEn),
        .LoadAddr   (LoadAddr),
        .LoadData   (LoadData),
        .Done       (Done),
        .DIN        (DIN),
        .Run        (Run),
        .Pc         (Pc),
        .Busy       (Busy),
        .Halted     (Halted),
        .Timeout    (Timeout),
        .InstrCount (InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (Run !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        chk(tag, 32'(Run), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_din"},     32'(DIN),        32'h0);
        chk({tag, "_run"},     32'(Run),        32'h0);
        chk({tag, "_pc"},      32'(Pc),         32'h0);
        chk({tag, "_busy"},    32'(Busy),       32'h0);
        chk({tag, "_halted"},  32'(Halted),     32'h0);
        chk({tag, "_timeout"}, 32'(Timeout),    32'h0);
        chk({tag, "_count"},   32'(InstrCount), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int gap;
        int n;

        Reset = 1'b1; Start = 1'b0; Stop = 1'b0; LoadEn = 1'b0;
        LoadAddr = '0; LoadData = '0; Done = 1'b0;
        step(2);
        chk_reset_state("reset");
        Reset = 1'b0;

        // Program ending in HALT
        for (int i = 0; i < 4; i++) begin
            LoadEn = 1'b1; LoadAddr = AW'(i); LoadData = prog1[i];
            step(1);
        end
        LoadEn = 1'b0;

        Start = 1'b1;
        step(1);
        Start = 1'b0;
        chk("t1_busy", 32'(Busy), 32'd1);
        step(1);
        chk("t1_run_pre", 32'(Run), 32'd0);
        step(1);
        chk("t1_run_lat3", 32'(Run), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0)
                wait_run("t1_run_rise");
            chk("t1_din", 32'(DIN), 32'(prog1[i]));
            step(1);
            Done = 1'b1;
            step(1);
            Done = 1'b0;
            chk("t1_run_fall", 32'(Run), 32'd0);
        end
        step(3);
        chk("t1_halted", 32'(Halted),     32'd1);
        chk("t1_pc",     32'(Pc),         32'd3);
        chk("t1_count",  32'(InstrCount), 32'd3);
        chk("t1_run",    32'(Run),        32'd0);
        chk("t1_busy_h", 32'(Busy),       32'd0);

        // Wrap-around program, loaded while halted
        for (int i = 0; i < 4; i++) begin
            LoadEn = 1'b1; LoadAddr = AW'(i); LoadData = prog2[i];
            step(1);
        end
        LoadEn = 1'b0;

        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(2);
        chk("t2_run_first", 32'(Run), 32'd1);
        chk("t2_count0", 32'(InstrCount), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("t2_pc",  32'(Pc),  32'(i % 4));
            chk("t2_din", 32'(DIN), 32'(prog2[i % 4]));
            if (i == 7)
                Stop = 1'b1;
            Done = 1'b1;
            step(1);
            Done = 1'b0;
            chk("t2_run_fall", 32'(Run), 32'd0);
            if (i < 7) begin
                gap = 0;
                while (Run !== 1'b1 && gap < 10) begin
                    gap++;
                    step(1);
                end
                chk("t2_gap", 32'(gap), 32'd3);
            end
        end
        step(1);
        Stop = 1'b0;
        chk("t2_busy",  32'(Busy),       32'd0);
        chk("t2_pc",    32'(Pc),         32'd3);
        chk("t2_count", 32'(InstrCount), 32'd8);
        chk("t2_run",   32'(Run),        32'd0);

        // Watchdog: Done never arrives
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(2);
        chk("t3_run_rise", 32'(Run), 32'd1);
        n = 0;
        while (Run === 1'b1 && n < 200) begin
            n++;
            step(1);
        end
        chk("t3_run_high_cycles", 32'(n), 32'd64);
        chk("t3_timeout", 32'(Timeout), 32'd1);
        chk("t3_busy",    32'(Busy),    32'd0);
        chk("t3_halted",  32'(Halted),  32'd0);
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        chk("t3_timeout_clr", 32'(Timeout), 32'd0);
        chk("t3_pc0",         32'(Pc),      32'd0);
        chk("t3_run_low",     32'(Run),     32'd0);
        step(2);
        chk("t3_run_again", 32'(Run), 32'd1);
        Stop = 1'b1;
        Done = 1'b1;
        step(1);
        Done = 1'b0;
        step(1);
        Stop = 1'b0;
        chk("t3_stop_busy",  32'(Busy),       32'd0);
        chk("t3_stop_count", 32'(InstrCount), 32'd1);

        // Load ignored while busy; Stop latched during WAIT of Pc=1
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(2);
        chk("t4_run0", 32'(Run), 32'd1);
        LoadEn = 1'b1; LoadAddr = 2'd1; LoadData = 16'hFFFF;
        step(1);
        LoadEn = 1'b0;
        Done = 1'b1;
        step(1);
        Done = 1'b0;
        wait_run("t4_run1");
        chk("t4_din1", 32'(DIN), 32'h1405);
        chk("t4_pc1",  32'(Pc),  32'd1);
        Stop = 1'b1;
        step(1);
        Stop = 1'b0;
        step(1);
        chk("t4_still_run", 32'(Run), 32'd1);
        Done = 1'b1;
        step(1);
        Done = 1'b0;
        chk("t4_run_fall", 32'(Run), 32'd0);
        step(1);
        chk("t4_busy",   32'(Busy),       32'd0);
        chk("t4_pc",     32'(Pc),         32'd1);
        chk("t4_run",    32'(Run),        32'd0);
        chk("t4_count",  32'(InstrCount), 32'd2);
        chk("t4_halted", 32'(Halted),     32'd0);

        // Reset in WAIT with Done in the same cycle
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(2);
        chk("t6_run", 32'(Run), 32'd1);
        Reset = 1'b1;
        Done  = 1'b1;
        step(1);
        Reset = 1'b0;
        Done  = 1'b0;
        chk_reset_state("t6_reset");
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(2);
        chk("t6_run_after", 32'(Run), 32'd1);
        chk("t6_store_kept", 32'(DIN), 32'h0280);
        Stop = 1'b1;
        Done = 1'b1;
        step(1);
        Done = 1'b0;
        step(1);
        Stop = 1'b0;
        chk("t6_idle", 32'(Busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
